// File: rtl/bcd_display_scanner_if.sv
// Load/display bundle between a BCD value source and the multiplexed display scanner.
// Latency: none; this file holds wires only.
// Backpressure: none; the scanner accepts load in every cycle.
interface bcd_display_scanner_if;
    logic        load;
    logic [11:0] bcd_in;
    logic [3:0]  digit;
    logic [1:0]  digit_place;
    logic [2:0]  digit_en;
    logic        blank;
    logic        bcd_error;
    logic        frame_tick;

    // Value source side: presents a value and a load strobe, and observes the display drive.
    modport master (
        output load, bcd_in,
        input  digit, digit_place, digit_en, blank, bcd_error, frame_tick
    );

    // Scanner side.
    modport slave (
        input  load, bcd_in,
        output digit, digit_place, digit_en, blank, bcd_error, frame_tick
    );
endinterface

// File: rtl/bcd_display_scanner.sv
// Time-multiplexes a 3-digit BCD value onto a common-drive display, with leading-zero blanking.
// Latency: outputs are decoded combinationally from registered state; a load is committed at the next frame end.
// Backpressure: none; load is always accepted and the last load before a frame end wins.
// Optional macro BCD_SCAN_BRIGHTNESS_PWM_EN adds a brightness[3:0] input that trims the on-time of each dwell.
module bcd_display_scanner #(
    parameter int SCAN_DIV = 1024,
    parameter int GUARD    = 16
) (
    input  logic clock,
    input  logic reset_n,
`ifdef BCD_SCAN_BRIGHTNESS_PWM_EN
    input  logic [3:0] brightness,
`endif
    bcd_display_scanner_if.slave bus
);
    localparam int CW = $clog2(SCAN_DIV);

    typedef enum logic [1:0] {
        SCAN_ONES     = 2'd0,
        SCAN_TENS     = 2'd1,
        SCAN_HUNDREDS = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [11:0]   active;
    logic [11:0]   shadow;
    logic          pending;
    logic          wrap;
    logic          frame_end;
    logic          suppressed;
    logic          blank_c;
    logic [3:0]    digit_c;
    logic [2:0]    en_c;

    // SCAN_DIV is a power of two, so the last dwell cycle is the all-ones count.
    assign wrap      = &cnt;
    assign frame_end = wrap && (state == SCAN_HUNDREDS);

    // Dwell counter: free-running, wraps every SCAN_DIV cycles.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Place state register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= SCAN_ONES;
        end else begin
            state <= state_nxt;
        end
    end

    // Place sequencing: ones -> tens -> hundreds -> ones, advancing only at dwell wrap.
    always_comb begin
        state_nxt = state;
        case (state)
            SCAN_ONES:     if (wrap) state_nxt = SCAN_TENS;
            SCAN_TENS:     if (wrap) state_nxt = SCAN_HUNDREDS;
            SCAN_HUNDREDS: if (wrap) state_nxt = SCAN_ONES;
            default:       state_nxt = SCAN_ONES;
        endcase
    end

    // Shadow/active value registers: the displayed value only changes at a frame boundary,
    // and a load landing exactly on the boundary goes straight to the display.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            active  <= '0;
            shadow  <= '0;
            pending <= 1'b0;
        end else begin
            if (bus.load) begin
                shadow <= bus.bcd_in;
            end
            if (frame_end) begin
                pending <= 1'b0;
                if (bus.load) begin
                    active <= bus.bcd_in;
                end else if (pending) begin
                    active <= shadow;
                end
            end else if (bus.load) begin
                pending <= 1'b1;
            end
        end
    end

    // Display decode: nibble select, leading-zero suppression, guard/brightness blanking, one-hot enable.
    always_comb begin
        digit_c    = 4'd0;
        suppressed = 1'b0;
        en_c       = 3'b000;
        case (state)
            SCAN_ONES: begin
                digit_c = active[3:0];
            end
            SCAN_TENS: begin
                digit_c    = active[7:4];
                suppressed = (active[11:8] == 4'd0) && (active[7:4] == 4'd0);
            end
            SCAN_HUNDREDS: begin
                digit_c    = active[11:8];
                suppressed = (active[11:8] == 4'd0);
            end
            default: begin
                digit_c    = 4'd0;
                suppressed = 1'b1;
            end
        endcase
        blank_c = (cnt < CW'(GUARD)) || suppressed;
`ifdef BCD_SCAN_BRIGHTNESS_PWM_EN
        if (cnt[CW-1 -: 4] > brightness) begin
            blank_c = 1'b1;
        end
`endif
        if (!blank_c) begin
            case (state)
                SCAN_ONES:     en_c = 3'b001;
                SCAN_TENS:     en_c = 3'b010;
                SCAN_HUNDREDS: en_c = 3'b100;
                default:       en_c = 3'b000;
            endcase
        end
    end

    assign bus.digit       = digit_c;
    assign bus.digit_place = state;
    assign bus.digit_en    = en_c;
    assign bus.blank       = blank_c;
    assign bus.frame_tick  = frame_end;
    assign bus.bcd_error   = (active[11:8] > 4'd9) || (active[7:4] > 4'd9) || (active[3:0] > 4'd9);

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner with SCAN_DIV=32, GUARD=4.
// Outputs are sampled and inputs driven on the falling clock edge.
// Frame-level vectors come from a hand-filled table; boundary cases are separate sequences.
module tb_bcd_display_scanner;
    localparam int SCAN_DIV = 32;
    localparam int GUARD    = 4;
    localparam int FRAME    = 3 * SCAN_DIV;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    bcd_display_scanner_if bus();
`ifdef BCD_SCAN_BRIGHTNESS_PWM_EN
    logic [3:0] brightness = 4'd15;
`endif

    bcd_display_scanner #(.SCAN_DIV(SCAN_DIV), .GUARD(GUARD)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
`ifdef BCD_SCAN_BRIGHTNESS_PWM_EN
        .brightness (brightness),
`endif
        .bus        (bus)
    );

    typedef struct {
        logic [11:0] val;     // value loaded and expected on the display
        logic [2:0]  sup;     // bit n set: place n expected blank for the whole dwell
        logic        err;     // expected bcd_error
        int          frames;  // frames to check after commit
    } vec_t;

    vec_t vecs[6];
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   bright = 15;  // highest cnt/2 value at which the display may be lit

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_load(input logic [11:0] v);
        bus.load   = 1'b1;
        bus.bcd_in = v;
        @(negedge clock);
        bus.load   = 1'b0;
    endtask

    // Leaves the bench at the falling edge where frame_tick is high.
    task automatic wait_tick();
        int k = 0;
        while (bus.frame_tick !== 1'b1 && k < 4 * FRAME) begin
            @(negedge clock);
            k++;
        end
        n_cmp++;
        if (bus.frame_tick !== 1'b1) begin
            n_bad++;
            $display("FAIL frame_tick_timeout: got no tick within %0d cycles, expected one", 4 * FRAME);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".digit"},       bus.digit,       0);
        check({tag, ".digit_place"}, bus.digit_place, 0);
        check({tag, ".blank"},       bus.blank,       1);
        check({tag, ".digit_en"},    bus.digit_en,    0);
        check({tag, ".bcd_error"},   bus.bcd_error,   0);
        check({tag, ".frame_tick"},  bus.frame_tick,  0);
        check({tag, ".pending"},     dut.pending,     0);
    endtask

    // Entered at cnt 0 of place 0; checks one whole frame cycle by cycle.
    task automatic check_frame(input logic [11:0] val, input logic [2:0] sup, input logic err);
        int p;
        int c;
        logic bl;
        logic [2:0] en;
        for (int i = 0; i < FRAME; i++) begin
            p  = i / SCAN_DIV;
            c  = i % SCAN_DIV;
            bl = (c < GUARD) || sup[p] || ((c / 2) > bright);
            en = bl ? 3'b000 : 3'(1 << p);
            check("digit_place", bus.digit_place, p);
            check("digit",       bus.digit,       val[4*p +: 4]);
            check("blank",       bus.blank,       bl);
            check("digit_en",    bus.digit_en,    en);
            check("bcd_error",   bus.bcd_error,   err);
            check("frame_tick",  bus.frame_tick,  (i == FRAME - 1));
            @(negedge clock);
        end
    endtask

    initial begin
        vecs[0] = '{val: 12'h123, sup: 3'b000, err: 1'b0, frames: 2};
        vecs[1] = '{val: 12'h007, sup: 3'b110, err: 1'b0, frames: 1};
        vecs[2] = '{val: 12'h000, sup: 3'b110, err: 1'b0, frames: 1};
        vecs[3] = '{val: 12'h1A2, sup: 3'b000, err: 1'b1, frames: 1};
        vecs[4] = '{val: 12'h102, sup: 3'b000, err: 1'b0, frames: 1};
        vecs[5] = '{val: 12'h045, sup: 3'b100, err: 1'b0, frames: 1};

        // Reset while load is asserted: nothing may be captured.
        reset_n    = 1'b0;
        bus.load   = 1'b1;
        bus.bcd_in = 12'h888;
        step(3);
        check_reset_outputs("reset");
        bus.load = 1'b0;
        reset_n  = 1'b1;

        // Table: load mid-frame, commit at the next tick, then check whole frames.
        foreach (vecs[v]) begin
            step(10);
            do_load(vecs[v].val);
            wait_tick();
            @(negedge clock);
            for (int f = 0; f < vecs[v].frames; f++) begin
                check_frame(vecs[v].val, vecs[v].sup, vecs[v].err);
            end
        end

        // Load 999 during the tens dwell: the rest of this frame keeps showing 045.
        step(40);
        do_load(12'h999);
        for (int i = 41; i < FRAME; i++) begin
            check("hold_045.digit", bus.digit, 12'h045 >> (4 * (i / SCAN_DIV)) & 12'hF);
            @(negedge clock);
        end
        check_frame(12'h999, 3'b000, 1'b0);

        // Load coinciding with frame_tick goes straight to the display with nothing pending.
        step(5);
        wait_tick();
        do_load(12'h321);
        check("tick_load.digit_place", bus.digit_place, 0);
        check("tick_load.digit",       bus.digit,       1);
        check("tick_load.pending",     dut.pending,     0);
        wait_tick();
        @(negedge clock);
        check_frame(12'h321, 3'b000, 1'b0);

        // Reset in the hundreds dwell with a load pending: the pending value is lost.
        step(70);
        do_load(12'h777);
        check("pre_reset.pending", dut.pending, 1);
        reset_n = 1'b0;
        step(2);
        check_reset_outputs("mid_reset");
        reset_n = 1'b1;
        check_frame(12'h000, 3'b110, 1'b0);
        check_frame(12'h000, 3'b110, 1'b0);
`ifdef BCD_SCAN_BRIGHTNESS_PWM_EN
        brightness = 4'd3;
        bright     = 3;
        check_frame(12'h000, 3'b110, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
